reg_wb_ctrl: RTL

Writeback controller on the write side of the 32x32 register file. Merges two result sources onto the single register-file write port: the in-order pipeline result, which cannot stall, and a long-latency unit (mul/div) result delivered by valid/ready handshake. Long-latency results are buffered in a small FIFO. A 32-bit busy scoreboard lets decode detect pending destinations.

---
 rtl/reg_wb_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/reg_wb_ctrl.sv
// ============================================================================
// reg_wb_ctrl
// ----------------------------------------------------------------------------
// Writeback controller on the write side of the register file. Two result
// sources share the single register-file write port:
//   - the in-order pipeline result, which can never be stalled, and
//   - a long-latency unit (mul/div) result, accepted by valid/ready handshake
//     and buffered in a small FIFO until the write port is free.
// A busy scoreboard tracks destinations reserved by issued long-latency ops
// so decode can detect hazards on pending registers.
//
// Ports
//   clk, rst              clock and asynchronous active-high reset
//   p_valid/p_addr/p_data pipeline result (always accepted, has priority)
//   p_hold                registered request for upstream to idle one cycle
//                         so a starved FIFO entry can drain
//   l_valid/l_addr/l_data long-latency result, pushed when l_valid && l_ready
//   l_ready               combinational, high while the FIFO has a free slot
//   iss_valid/iss_addr    long-latency issue, reserves iss_addr in scoreboard
//   chk_addr1/2           scoreboard query addresses
//   chk_busy1/2           combinational busy bit of the queried registers
//   wr_en/wr_addr/wr_data registered register-file write port
// ============================================================================
module reg_wb_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p_valid,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic              p_hold,

   input  logic              l_valid,
   output logic              l_ready,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_data,

   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,

   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              chk_busy1,
   output logic              chk_busy2,

   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SC_W  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

   localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [SC_W-1:0]  STARVE_LAST = SC_W'(STARVE_MAX - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_next;

   logic              wr_from_l;
   logic [SC_W-1:0]   starve_cnt;

   // ------------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------------
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              sel_pipe;
   logic              sel_fifo;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   // The FIFO accepts a new entry whenever at least one slot is free. This is
   // purely a function of the occupancy count, so it is high during reset and
   // drops in the same cycle the last slot is filled.
   assign fifo_empty = (count == '0);
   assign l_ready    = (count != FULL_COUNT);
   assign push       = l_valid && l_ready;

   assign head_addr  = fifo_addr_mem[rd_ptr];
   assign head_data  = fifo_data_mem[rd_ptr];

   // Candidate selection for the single write port. The pipeline cannot be
   // stalled, so it always wins; the FIFO head is only taken in cycles the
   // pipeline leaves free. A selected candidate whose destination is
   // register 0 is still consumed (so the FIFO drains) but never writes.
   always_comb begin
      sel_pipe  = p_valid;
      sel_fifo  = !p_valid && !fifo_empty;
      sel_addr  = head_addr;
      sel_data  = head_data;
      if (sel_pipe) begin
         sel_addr = p_addr;
         sel_data = p_data;
      end
      sel_write = (sel_pipe || sel_fifo) && (sel_addr != '0);
   end

   assign pop = sel_fifo;

   // ------------------------------------------------------------------------
   // FIFO storage
   // ------------------------------------------------------------------------
   // Entry storage carries no reset: whether an entry is live is decided only
   // by the pointers and count, so stale contents after reset are never seen.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_mem[wr_ptr] <= l_addr;
         fifo_data_mem[wr_ptr] <= l_data;
      end
   end

   // Pointers wrap naturally because the depth is a power of two; the count
   // is what tells full apart from empty. A push and a pop on the same edge
   // both happen and leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Register-file write port
   // ------------------------------------------------------------------------
   // The write port is fully registered. Address and data only move when a
   // real write is issued, so an idle port keeps presenting the last write.
   // wr_from_l remembers that the write in flight came from the FIFO, which
   // is what lets the scoreboard release the reservation on commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_from_l <= 1'b0;
      end else begin
         wr_en     <= sel_write;
         wr_from_l <= sel_fifo && sel_write;
         if (sel_write) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Busy scoreboard
   // ------------------------------------------------------------------------
   // A reservation is released on the edge that ends a FIFO-sourced write
   // cycle, i.e. the edge at which the register file actually commits it.
   // The set is applied after the clear so a new issue to the same register
   // on that edge keeps it busy. Pipeline writes are never tracked here, and
   // register 0 can never be reserved.
   always_comb begin
      busy_next = busy;
      if (wr_en && wr_from_l) begin
         busy_next[wr_addr] = 1'b0;
      end
      if (iss_valid && (iss_addr != '0)) begin
         busy_next[iss_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Scoreboard state register; queries see only reservations from prior edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Queries read the registered scoreboard, so a reservation made in one
   // cycle is reported from the next cycle on. Address 0 is forced to idle.
   assign chk_busy1 = (chk_addr1 != '0) && busy[chk_addr1];
   assign chk_busy2 = (chk_addr2 != '0) && busy[chk_addr2];

   // ------------------------------------------------------------------------
   // Starvation guard
   // ------------------------------------------------------------------------
   // Counts consecutive edges where a FIFO entry waited while the pipeline
   // took the port. Once the run reaches STARVE_MAX edges, p_hold is raised
   // for exactly one cycle to ask upstream for a bubble, and the run restarts.
   // Any edge where the FIFO is empty or its head is taken ends the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         p_hold     <= 1'b0;
      end else if (fifo_empty || !p_valid) begin
         starve_cnt <= '0;
         p_hold     <= 1'b0;
      end else if (starve_cnt == STARVE_LAST) begin
         starve_cnt <= '0;
         p_hold     <= 1'b1;
      end else begin
         starve_cnt <= starve_cnt + SC_W'(1);
         p_hold     <= 1'b0;
      end
   end

endmodule
